// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the BIOS loader and the CPU fetch/data ports
//
// Build option: define RAM_ARB_FIXED_PRIO_EN to make RUN-mode arbitration
// fixed priority (data beats instruction). In that build the last_winner
// register does not exist. The default build uses round-robin.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_booted                     BIOS finished; sticky switch from BOOT to RUN
//   i_b_* / o_b_*                BIOS request, grant and read return (BOOT only)
//   i_i_* / o_i_*                CPU instruction fetch (read-only) request and return
//   i_d_* / o_d_*                CPU data request and return
//   o_ram_* / i_ram_rdata        RAM command (combinational from the winner) and
//                                read data, valid one cycle after a read command
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_booted,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic [3:0]            i_b_be,
    input  logic [ADDR_WIDTH:0]   i_b_addr,
    input  logic [DATA_WIDTH:0]   i_b_wdata,
    output logic                  o_b_gnt,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH:0]   o_b_rdata,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH:0]   i_i_addr,
    output logic                  o_i_gnt,
    output logic                  o_i_rvalid,
    output logic [DATA_WIDTH:0]   o_i_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [3:0]            i_d_be,
    input  logic [ADDR_WIDTH:0]   i_d_addr,
    input  logic [DATA_WIDTH:0]   i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_WIDTH:0]   o_d_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [3:0]            o_ram_be,
    output logic [ADDR_WIDTH:0]   o_ram_addr,
    output logic [DATA_WIDTH:0]   o_ram_wdata,
    input  logic [DATA_WIDTH:0]   i_ram_rdata
);
    typedef enum logic {BOOT, RUN} mode_t;
    typedef enum logic [1:0] {OWN_B, OWN_I, OWN_D} owner_t;

    mode_t                mode;
    owner_t               owner;
    logic                 pend;
    logic                 run;
    logic                 rd_issue;
    logic [DATA_WIDTH:0]  b_hold, i_hold, d_hold;

    // Grants are forced low while reset is asserted so the RAM sees no command
    assign run = rst_n && mode == RUN;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        o_b_gnt = rst_n && mode == BOOT && i_b_req;
        o_d_gnt = run && i_d_req;
        o_i_gnt = run && i_i_req && !i_d_req;
    end
`else
    typedef enum logic {WIN_I, WIN_D} win_t;
    win_t last_winner;

    // On a tie the port that did not win the previous granted cycle goes first
    always_comb begin
        o_b_gnt = rst_n && mode == BOOT && i_b_req;
        o_i_gnt = run && i_i_req && (!i_d_req || last_winner == WIN_D);
        o_d_gnt = run && i_d_req && (!i_i_req || last_winner == WIN_I);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_winner <= WIN_D;
        else if (o_i_gnt || o_d_gnt)
            last_winner <= o_i_gnt ? WIN_I : WIN_D;
    end
`endif

    // The fetch port is read-only and always reads the full word
    always_comb begin
        o_ram_en    = o_b_gnt || o_i_gnt || o_d_gnt;
        o_ram_we    = o_b_gnt ? i_b_we : o_d_gnt ? i_d_we : 1'b0;
        o_ram_be    = o_b_gnt ? i_b_be : o_i_gnt ? 4'b1111 : o_d_gnt ? i_d_be : 4'b0000;
        o_ram_addr  = o_b_gnt ? i_b_addr : o_i_gnt ? i_i_addr : o_d_gnt ? i_d_addr : '0;
        o_ram_wdata = o_b_gnt ? i_b_wdata : o_d_gnt ? i_d_wdata : '0;
        rd_issue    = o_ram_en && !o_ram_we;
    end

    // Only the owner of the pending read sees live RAM data; others keep their last word
    always_comb begin
        o_b_rvalid = pend && owner == OWN_B;
        o_i_rvalid = pend && owner == OWN_I;
        o_d_rvalid = pend && owner == OWN_D;
        o_b_rdata  = o_b_rvalid ? i_ram_rdata : b_hold;
        o_i_rdata  = o_i_rvalid ? i_ram_rdata : i_hold;
        o_d_rdata  = o_d_rvalid ? i_ram_rdata : d_hold;
    end

    // Mode is sticky: once booted is seen, only reset returns to BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= BOOT;
            pend   <= 1'b0;
            owner  <= OWN_B;
            b_hold <= '0;
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (mode == BOOT && i_booted)
                mode <= RUN;
            pend <= rd_issue;
            if (rd_issue)
                owner <= o_b_gnt ? OWN_B : o_i_gnt ? OWN_I : OWN_D;
            if (o_b_rvalid)
                b_hold <= i_ram_rdata;
            if (o_i_rvalid)
                i_hold <= i_ram_rdata;
            if (o_d_rvalid)
                d_hold <= i_ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        i_booted = 0;
    logic        i_b_req = 0, i_b_we = 0;
    logic [3:0]  i_b_be = 0;
    logic [31:0] i_b_addr = 0, i_b_wdata = 0;
    logic        o_b_gnt, o_b_rvalid;
    logic [31:0] o_b_rdata;
    logic        i_i_req = 0;
    logic [31:0] i_i_addr = 0;
    logic        o_i_gnt, o_i_rvalid;
    logic [31:0] o_i_rdata;
    logic        i_d_req = 0, i_d_we = 0;
    logic [3:0]  i_d_be = 0;
    logic [31:0] i_d_addr = 0, i_d_wdata = 0;
    logic        o_d_gnt, o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_ram_en, o_ram_we;
    logic [3:0]  o_ram_be;
    logic [31:0] o_ram_addr, o_ram_wdata;
    logic [31:0] i_ram_rdata = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .i_booted(i_booted),
        .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_be(i_b_be), .i_b_addr(i_b_addr),
        .i_b_wdata(i_b_wdata), .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_gnt(o_i_gnt), .o_i_rvalid(o_i_rvalid),
        .o_i_rdata(o_i_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_be(o_ram_be), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) begin
                for (int k = 0; k < 4; k++)
                    if (o_ram_be[k]) mem[o_ram_addr[7:0]][k*8 +: 8] <= o_ram_wdata[k*8 +: 8];
            end else begin
                i_ram_rdata <= mem[o_ram_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic [2:0]  port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any rvalid must match the oldest expected read due this cycle
    always @(negedge clk) begin
        logic [2:0]  got;
        logic [31:0] gd;
        exp_t        e;
        got = {o_b_rvalid, o_i_rvalid, o_d_rvalid};
        if (q.size() != 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            gd = e.port[2] ? o_b_rdata : e.port[1] ? o_i_rdata : o_d_rdata;
            chk("rvalid_port", {61'd0, got}, {61'd0, e.port});
            chk("rdata", {32'd0, gd}, {32'd0, e.data});
        end else if (got != 3'b000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rvalid: got %b expected 000 (cycle %0d)", got, cyc);
        end
    end

    // Check grants mid-cycle; a granted read queues its expected return for next cycle
    task automatic tick(input string name, input logic [2:0] eg, input logic [31:0] ed, input bit rd = 1);
        exp_t e;
        @(negedge clk);
        chk(name, {61'd0, o_b_gnt, o_i_gnt, o_d_gnt}, {61'd0, eg});
        if (rd && ((eg == 3'b100 && !i_b_we) || eg == 3'b010 || (eg == 3'b001 && !i_d_we))) begin
            e.port = eg;
            e.data = ed;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  eg;
        logic [31:0] ed;
        i_b_req = 1;
        i_i_req = 1;
        i_d_req = 1;
        #3;
        chk("rst_gnt", {61'd0, o_b_gnt, o_i_gnt, o_d_gnt}, 64'd0);
        chk("rst_rvalid", {61'd0, o_b_rvalid, o_i_rvalid, o_d_rvalid}, 64'd0);
        chk("rst_ram_cmd", {58'd0, o_ram_en, o_ram_we, o_ram_be}, 64'd0);
        chk("rst_ram_addr_wdata", {o_ram_addr, o_ram_wdata}, 64'd0);
        chk("rst_rdata", {o_b_rdata, o_i_rdata ^ o_d_rdata}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        // BOOT: BIOS write, CPU requests held high but not granted
        i_b_req = 1; i_b_we = 1; i_b_be = 4'hF; i_b_addr = 32'h10; i_b_wdata = 32'hDEADBEEF;
        #2;
        chk("boot_wr_ram_cmd", {58'd0, o_ram_en, o_ram_we, o_ram_be}, {58'd0, 2'b11, 4'hF});
        chk("boot_wr_ram_addr_wdata", {o_ram_addr, o_ram_wdata}, {32'h10, 32'hDEADBEEF});
        tick("boot_wr_gnt", 3'b100, 32'h0);
        i_b_we = 0;
        tick("boot_rd_gnt", 3'b100, 32'hDEADBEEF);
        i_b_we = 1; i_b_addr = 32'h20; i_b_wdata = 32'h11223344;
        tick("boot_wr2_gnt", 3'b100, 32'h0);

        // Booted sampled while a BIOS read is issued: read still returns to BIOS
        i_b_we = 0; i_booted = 1;
        tick("switch_rd_gnt", 3'b100, 32'h11223344);
        i_booted = 0; i_d_req = 0; i_i_addr = 32'h10;
        tick("run_first_i_gnt", 3'b010, 32'hDEADBEEF);

        // Single requester: data port granted every cycle
        i_b_req = 0; i_i_req = 0; i_d_req = 1; i_d_we = 0; i_d_addr = 32'h10;
        tick("single_d0", 3'b001, 32'hDEADBEEF);
        i_d_addr = 32'h20;
        tick("single_d1", 3'b001, 32'h11223344);
        i_d_addr = 32'h10;
        tick("single_d2", 3'b001, 32'hDEADBEEF);

        // Contention: round-robin I,D,I,D or fixed D,D,D,D
        i_i_req = 1; i_i_addr = 32'h20;
        #2;
        chk("i_rdata_hold", {32'd0, o_i_rdata}, {32'd0, 32'hDEADBEEF});
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            eg = 3'b001;
`else
            eg = (k % 2 == 0) ? 3'b010 : 3'b001;
`endif
            ed = (eg == 3'b010) ? 32'h11223344 : 32'hDEADBEEF;
            tick("contend_gnt", eg, ed);
        end

        // Idle cycle: no RAM access
        i_i_req = 0; i_d_req = 0;
        #2;
        chk("idle_ram_en", {63'd0, o_ram_en}, 64'd0);
        tick("idle_gnt", 3'b000, 32'h0);

        // Byte write into 0x11223344 then fetch it back
        i_d_req = 1; i_d_we = 1; i_d_be = 4'b0010; i_d_addr = 32'h20; i_d_wdata = 32'h0000AB00;
        tick("byte_wr_gnt", 3'b001, 32'h0);
        i_d_req = 0; i_d_we = 0; i_i_req = 1; i_i_addr = 32'h20;
        tick("byte_rd_gnt", 3'b010, 32'h1122AB44);

        // Reset the cycle after a granted read: the return is discarded
        i_i_addr = 32'h10;
        tick("rst_rd_gnt", 3'b010, 32'h0, 0);
        rst_n = 0;
        #2;
        chk("midrst_rvalid", {61'd0, o_b_rvalid, o_i_rvalid, o_d_rvalid}, 64'd0);
        chk("midrst_i_gnt", {63'd0, o_i_gnt}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        i_b_req = 1; i_b_we = 0; i_b_addr = 32'h10;
        #2;
        chk("post_rst_rvalid", {61'd0, o_b_rvalid, o_i_rvalid, o_d_rvalid}, 64'd0);
        tick("post_rst_boot_gnt", 3'b100, 32'hDEADBEEF);
        i_b_req = 0; i_i_req = 0;
        tick("end_idle0", 3'b000, 32'h0);
        tick("end_idle1", 3'b000, 32'h0);
        chk("sb_drained", {32'd0, q.size()}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
